// File: rtl/convo_stream_engine_if.sv
// Pixel stream bundle for convo_stream_engine: input pixel channel and output pixel channel,
// each a valid/ready handshake. The engine uses the slave view, the pixel source/sink the master view.
interface convo_stream_engine_if #(
    parameter int DW = 8,
    parameter int CH = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [CH*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CH*DW-1:0]  out_data;
    logic              out_sof;
    logic              out_eol;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eol
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eol
    );
endinterface

// File: rtl/convo_stream_engine.sv
// Streaming KxK convolution with zero padding: raster line buffers feed a KxK window, one signed
// kernel is applied to every channel, and each output is rounded, shifted and clamped.
module convo_stream_engine #(
    parameter int DW        = 8,
    parameter int CH        = 3,
    parameter int K         = 3,
    parameter int COEF_W    = 8,
    parameter int MAX_WIDTH = 1280
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              cfg_width,
    input  logic [15:0]              cfg_height,
    input  logic [4:0]               cfg_shift,
    input  logic                     start,
    input  logic                     coef_we,
    input  logic [$clog2(K*K)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    convo_stream_engine_if.slave     strm,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);
    localparam int C      = (K - 1) / 2;
    localparam int NT     = K * K;
    localparam int PW     = $clog2(MAX_WIDTH);
    localparam int PIX_W  = CH * DW;
    localparam int PROD_W = DW + COEF_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NT);
    localparam int RW     = ACC_W + 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                   r_state, w_state_nxt;
    logic [15:0]              r_w, r_h;
    logic [15:0]              r_nx, r_ny, r_wx, r_wy;
    logic [31:0]              r_total, r_d, r_icnt, r_acnt, r_ocnt;
    logic [PW-1:0]            r_ptr;
    logic signed [COEF_W-1:0] r_coef [NT];
    logic                     r_win_vld, r_out_valid, r_out_sof, r_out_eol;
    logic                     r_done, r_cfg_err;
    logic [PIX_W-1:0]         r_out_data;
    logic [PIX_W-1:0]         r_lb  [K-1][MAX_WIDTH];
    logic [PIX_W-1:0]         r_win [K][K];

    logic                     w_stall, w_en, w_adv, w_cfg_ok, w_start_ok, w_start_bad;
    logic                     w_last_out, w_emit, w_tap_ok;
    logic [PIX_W-1:0]         w_pix, w_res;
    logic [PIX_W-1:0]         w_row_in [K];
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [PROD_W-1:0] w_samp, w_coefx, w_prod;

    function automatic logic [DW-1:0] f_round_sat(input logic signed [ACC_W-1:0] acc,
                                                  input logic [4:0] sh);
        logic signed [RW-1:0] v;
        logic signed [RW-1:0] rnd;
        logic signed [RW-1:0] vmax;
        vmax = RW'((1 << DW) - 1);
        rnd  = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        v = (RW'(acc) + rnd) >>> sh;
        if (v < 0) return '0;
        else if (v > vmax) return '1;
        else return v[DW-1:0];
    endfunction

    assign w_stall     = r_out_valid & ~strm.out_ready;
    assign w_en        = ~w_stall;
    assign w_emit      = (r_acnt >= r_d);
    assign w_last_out  = r_out_valid & strm.out_ready & (r_ocnt == r_total - 32'd1);
    assign w_cfg_ok    = (32'(cfg_width) >= K) && (32'(cfg_width) <= MAX_WIDTH) &&
                         (32'(cfg_height) >= K);

    assign strm.in_ready  = (r_state == S_RUN) & w_en;
    assign strm.out_valid = r_out_valid;
    assign strm.out_data  = r_out_data;
    assign strm.out_sof   = r_out_sof;
    assign strm.out_eol   = r_out_eol;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign cfg_err        = r_cfg_err;

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_adv = strm.in_valid & w_en;
                if (w_adv && (r_icnt == r_total - 32'd1)) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                // Zero pixels push the last C rows and C columns through to the window centre
                w_adv = w_en & (r_acnt < r_total + r_d);
                if (w_last_out) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pix = (r_state == S_RUN) ? strm.in_data : '0;
        for (int j = 0; j < K - 1; j++) w_row_in[j] = r_lb[j][r_ptr];
        w_row_in[K-1] = w_pix;
    end

    // Taps outside the frame read stale or wrapped pixels and are masked here
    always_comb begin
        w_res    = '0;
        w_acc    = '0;
        w_samp   = '0;
        w_coefx  = '0;
        w_prod   = '0;
        w_tap_ok = 1'b0;
        for (int c = 0; c < CH; c++) begin
            w_acc = '0;
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    w_tap_ok = (int'(r_wy) + ky - C >= 0) && (int'(r_wy) + ky - C < int'(r_h)) &&
                               (int'(r_wx) + kx - C >= 0) && (int'(r_wx) + kx - C < int'(r_w));
                    w_samp   = PROD_W'(signed'({1'b0, r_win[ky][kx][c*DW +: DW]}));
                    w_coefx  = PROD_W'(r_coef[ky*K + kx]);
                    w_prod   = w_samp * w_coefx;
                    if (w_tap_ok) w_acc = w_acc + ACC_W'(w_prod);
                end
            end
            w_res[c*DW +: DW] = f_round_sat(w_acc, cfg_shift);
        end
    end

    // Stage p0: line buffers and window shift on every advance
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int j = 0; j < K - 1; j++) r_lb[j][r_ptr] <= w_row_in[j+1];
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K - 1; kx++) r_win[ky][kx] <= r_win[ky][kx+1];
                r_win[ky][K-1] <= w_row_in[ky];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_nx        <= '0;
            r_ny        <= '0;
            r_wx        <= '0;
            r_wy        <= '0;
            r_total     <= '0;
            r_d         <= '0;
            r_icnt      <= '0;
            r_acnt      <= '0;
            r_ocnt      <= '0;
            r_ptr       <= '0;
            r_win_vld   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            for (int i = 0; i < NT; i++) r_coef[i] <= (i == C*K + C) ? COEF_W'(1) : '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= ((r_state == S_FLUSH) & w_last_out) | w_start_bad;
            r_cfg_err <= w_start_bad;

            if ((r_state == S_IDLE) && coef_we && (32'(coef_addr) < NT))
                r_coef[coef_addr] <= coef_data;

            if (w_adv) begin
                r_acnt <= r_acnt + 32'd1;
                if (r_state == S_RUN) r_icnt <= r_icnt + 32'd1;
                r_ptr <= (16'(r_ptr) == r_w - 16'd1) ? '0 : r_ptr + PW'(1);
                if (w_emit) begin
                    r_wx <= r_nx;
                    r_wy <= r_ny;
                    if (r_nx == r_w - 16'd1) begin
                        r_nx <= '0;
                        r_ny <= r_ny + 16'd1;
                    end else begin
                        r_nx <= r_nx + 16'd1;
                    end
                end
            end

            // Stage p1: registered output, frozen while the sink stalls
            if (w_en) begin
                r_win_vld   <= w_adv & w_emit;
                r_out_valid <= r_win_vld;
                r_out_sof   <= r_win_vld & (r_wx == 16'd0) & (r_wy == 16'd0);
                r_out_eol   <= r_win_vld & (r_wx == r_w - 16'd1);
                if (r_win_vld) r_out_data <= w_res;
            end
            if (r_out_valid & strm.out_ready) r_ocnt <= r_ocnt + 32'd1;

            if (w_start_ok) begin
                r_w       <= cfg_width;
                r_h       <= cfg_height;
                r_total   <= 32'(cfg_width) * 32'(cfg_height);
                r_d       <= 32'(C) * 32'(cfg_width) + 32'(C);
                r_icnt    <= '0;
                r_acnt    <= '0;
                r_ocnt    <= '0;
                r_ptr     <= '0;
                r_nx      <= '0;
                r_ny      <= '0;
                r_win_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_convo_stream_engine.sv
// Directed bench for convo_stream_engine: a reference convolution fills a queue of expected
// pixels per frame, which are popped and compared at each output handshake.
module tb_convo_stream_engine;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int K  = 3;
    localparam int PW = CH * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       cfg_width = '0;
    logic [15:0]       cfg_height = '0;
    logic [4:0]        cfg_shift = '0;
    logic              start = 1'b0;
    logic              coef_we = 1'b0;
    logic [3:0]        coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic              busy, done, cfg_err;

    int                errors = 0;
    int                checks = 0;
    logic [PW+1:0]     q_exp [$];
    logic [PW-1:0]     pix [256];
    int                kc [9];

    always #5 clk = ~clk;

    convo_stream_engine_if #(.DW(DW), .CH(CH)) bus ();

    convo_stream_engine #(.DW(DW), .CH(CH), .K(K), .COEF_W(8), .MAX_WIDTH(1280)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_shift(cfg_shift), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .strm(bus), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 9; i++) kc[i] = (i == 4) ? 1 : 0;
    endtask

    task automatic write_kernel();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            coef_we = 1'b1;
            coef_addr = 4'(i);
            coef_data = 8'(kc[i]);
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic build_expected(input int w, input int h, input int shift);
        logic [PW-1:0] d;
        int acc, yy, xx;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                d = '0;
                for (int c = 0; c < CH; c++) begin
                    acc = 0;
                    for (int ky = 0; ky < 3; ky++) begin
                        for (int kx = 0; kx < 3; kx++) begin
                            yy = y + ky - 1;
                            xx = x + kx - 1;
                            if (yy >= 0 && yy < h && xx >= 0 && xx < w)
                                acc += int'(pix[yy*w + xx][c*DW +: DW]) * kc[ky*3 + kx];
                        end
                    end
                    if (shift > 0) acc += 1 << (shift - 1);
                    acc = acc >>> shift;
                    if (acc < 0) acc = 0;
                    if (acc > 255) acc = 255;
                    d[c*DW +: DW] = 8'(acc);
                end
                q_exp.push_back({(x == w - 1), (x == 0 && y == 0), d});
            end
        end
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int shift,
                             input int rdy_pct, input int gap_pct, input bit poke);
        int sent, cyc;
        logic [PW+1:0] e;
        build_expected(w, h, shift);
        @(negedge clk);
        cfg_width = 16'(w);
        cfg_height = 16'(h);
        cfg_shift = 5'(shift);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        sent = 0;
        cyc = 0;
        while (q_exp.size() != 0 && cyc < 3000) begin
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            bus.in_valid = (sent < w*h) && ($urandom_range(99) >= gap_pct);
            bus.in_data = (sent < w*h) ? pix[sent] : '0;
            coef_we = poke && ($urandom_range(2) == 0);
            coef_addr = 4'($urandom_range(8));
            coef_data = 8'($urandom);
            #1;
            if (bus.out_valid && !bus.out_ready) chk({tag, "_stall_rdy"}, 32'(bus.in_ready), 32'd0);
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                e = q_exp.pop_front();
                chk({tag, "_data"}, 32'(bus.out_data), 32'(e[PW-1:0]));
                chk({tag, "_sof"}, 32'(bus.out_sof), 32'(e[PW]));
                chk({tag, "_eol"}, 32'(bus.out_eol), 32'(e[PW+1]));
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        coef_we = 1'b0;
        chk({tag, "_left"}, 32'(q_exp.size()), 32'd0);
        q_exp.delete();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_ovld"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
    endtask

    task automatic reject(input string tag, input int w, input int h);
        @(negedge clk);
        cfg_width = 16'(w);
        cfg_height = 16'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(cfg_err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_err_clr"}, 32'(cfg_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_noout"}, 32'(bus.out_valid), 32'd0);
            chk({tag, "_busy2"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_irdy"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_ovld"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_odata"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_sof"}, 32'(bus.out_sof), 32'd0);
        chk({tag, "_eol"}, 32'(bus.out_eol), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        int n, cyc;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("post_rst");

        // Identity kernel straight out of reset, ramp input
        set_identity();
        for (int i = 0; i < 12; i++) pix[i] = {3{8'(i)}};
        run_frame("t1", 4, 3, 0, 100, 0, 1'b0);

        // All-ones kernel on a constant image: 40 corners, 60 edges, 90 interior
        for (int i = 0; i < 9; i++) kc[i] = 1;
        write_kernel();
        for (int i = 0; i < 16; i++) pix[i] = {3{8'd10}};
        run_frame("t2", 4, 4, 0, 100, 0, 1'b0);

        // Rounding, negative clamp, positive saturation
        set_identity();
        kc[4] = 3;
        write_kernel();
        for (int i = 0; i < 9; i++) pix[i] = {3{8'd5}};
        run_frame("t3_rnd", 3, 3, 1, 100, 0, 1'b0);
        kc[4] = -1;
        write_kernel();
        for (int i = 0; i < 9; i++) pix[i] = {3{8'd7}};
        run_frame("t3_neg", 3, 3, 0, 100, 0, 1'b0);
        kc[4] = 2;
        write_kernel();
        for (int i = 0; i < 9; i++) pix[i] = {3{8'd200}};
        run_frame("t3_sat", 3, 3, 0, 100, 0, 1'b0);

        // All-ones frame again under random backpressure and input gaps
        for (int i = 0; i < 9; i++) kc[i] = 1;
        write_kernel();
        for (int i = 0; i < 16; i++) pix[i] = {3{8'd10}};
        run_frame("t4", 4, 4, 0, 50, 30, 1'b0);

        // Random kernel and per-channel pixels, coefficient writes poked during RUN
        for (int i = 0; i < 9; i++) kc[i] = int'($urandom_range(8)) - 4;
        write_kernel();
        for (int i = 0; i < 20; i++) pix[i] = PW'($urandom);
        run_frame("rnd", 5, 4, 2, 70, 20, 1'b1);

        // Illegal configurations
        reject("t6_w2", 2, 4);
        reject("t6_wmax", 1281, 4);
        reject("t6_h2", 4, 2);

        // Reset in the middle of a frame, then a clean identity frame
        for (int i = 0; i < 9; i++) kc[i] = 1;
        write_kernel();
        @(negedge clk);
        cfg_width = 16'd4;
        cfg_height = 16'd3;
        cfg_shift = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 6 && cyc < 100) begin
            bus.in_valid = 1'b1;
            bus.in_data = {3{8'(n + 100)}};
            #1;
            if (bus.in_ready) n++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("t5_fed", 32'(n), 32'd6);
        rst_n = 1'b0;
        #1;
        check_reset_state("t5_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_quiet", 32'(bus.out_valid), 32'd0);
        end
        set_identity();
        for (int i = 0; i < 12; i++) pix[i] = {3{8'(i)}};
        run_frame("t5", 4, 3, 0, 100, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
